// File: rtl/alu_add_sub_pipe_if.sv
// Operand/result handshake bundle for alu_add_sub_pipe.
// master drives operands and out_ready; slave is the ALU.
interface alu_add_sub_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             sat;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic             ovf_sticky;

  modport master (
    output in_valid, a, b, op, sat, acc_clr, out_ready,
    input  in_ready, out_valid, result, ovf, zero, neg, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, op, sat, acc_clr, out_ready,
    output in_ready, out_valid, result, ovf, zero, neg, ovf_sticky
  );
endinterface

// File: rtl/alu_add_sub_pipe.sv
// Registered signed add/sub with accumulator, wrap/saturate and valid/ready handshake.
// Define ALU_STICKY_OVF_EN to build the sticky overflow flag; otherwise ovf_sticky is 0.
module alu_add_sub_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic               clk,
  input logic               rst,
  alu_add_sub_pipe_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             neg_reg;
  logic [WIDTH-1:0] acc_reg;

  logic             in_ready_next;
  logic             accept;
  logic [WIDTH-1:0] opnd_l;
  logic [WIDTH-1:0] opnd_r;
  logic             is_sub;
  logic [WIDTH:0]   ext_l;
  logic [WIDTH:0]   ext_r;
  logic [WIDTH:0]   ext_r_inv;
  logic [WIDTH:0]   sum_next;
  logic             ovf_next;
  logic [WIDTH-1:0] result_next;

  assign in_ready_next = !rst && (!out_valid_reg || bus.out_ready);
  assign accept        = bus.in_valid && in_ready_next;

  // op[1] swaps in the accumulator as the left operand and a as the right one.
  assign opnd_l = bus.op[1] ? acc_reg : bus.a;
  assign opnd_r = bus.op[1] ? bus.a   : bus.b;
  assign is_sub = bus.op[0];
  assign ext_l  = {opnd_l[WIDTH-1], opnd_l};
  assign ext_r  = {opnd_r[WIDTH-1], opnd_r};

  // Subtract as l + ~r + 1 in WIDTH+1 bits so that r = MIN never needs a WIDTH-bit negate.
  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_inv
      assign ext_r_inv[gi] = ext_r[gi] ^ is_sub;
    end
  endgenerate

  always_comb begin
    sum_next    = ext_l + ext_r_inv + {{WIDTH{1'b0}}, is_sub};
    ovf_next    = sum_next[WIDTH] ^ sum_next[WIDTH-1];
    result_next = sum_next[WIDTH-1:0];
    if (bus.sat && ovf_next) begin
      result_next = sum_next[WIDTH] ? MIN_VAL : MAX_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      neg_reg       <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      result_reg    <= result_next;
      ovf_reg       <= ovf_next;
      zero_reg      <= (result_next == '0);
      neg_reg       <= result_next[WIDTH-1];
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // acc_clr outranks an accumulator op in the same cycle; that beat still used the old acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= ACC_INIT;
    end else if (bus.acc_clr) begin
      acc_reg <= ACC_INIT;
    end else if (accept && bus.op[1]) begin
      acc_reg <= result_next;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic ovf_sticky_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_reg <= 1'b0;
    end else if (accept && ovf_next) begin
      ovf_sticky_reg <= 1'b1;
    end else if (bus.acc_clr) begin
      ovf_sticky_reg <= 1'b0;
    end
  end

  assign bus.ovf_sticky = ovf_sticky_reg;
`else
  assign bus.ovf_sticky = 1'b0;
`endif

  assign bus.in_ready  = in_ready_next;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;
  assign bus.neg       = neg_reg;
endmodule

// File: tb/tb_alu_add_sub_pipe.sv
// Bench for alu_add_sub_pipe (WIDTH=8): integer reference model checked every cycle,
// plus directed beats with hand-computed results.
module tb_alu_add_sub_pipe;
  localparam int MAXV = 127;
  localparam int MINV = -128;
`ifdef ALU_STICKY_OVF_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   got[$];

  alu_add_sub_pipe_if #(.WIDTH(8)) bus ();

  alu_add_sub_pipe #(.WIDTH(8), .ACC_INIT(8'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int wrap8(input int t);
    logic [7:0] w;
    w = t[7:0];
    return int'($signed(w));
  endfunction

  // Reference model: plain integer arithmetic, then clamp or wrap to 8 bits.
  int   m_acc;
  int   m_result;
  bit   m_valid, m_ovf, m_zero, m_neg, m_sticky, m_init;
  int   cx, cy, ct, c_r;
  bit   c_o, m_accept;

  initial m_init = 1'b0;

  always_comb begin
    cx = bus.op[1] ? m_acc : int'($signed(bus.a));
    cy = bus.op[1] ? int'($signed(bus.a)) : int'($signed(bus.b));
    ct = bus.op[0] ? cx - cy : cx + cy;
    c_o = (ct > MAXV) || (ct < MINV);
    c_r = wrap8(ct);
    if (c_o && bus.sat) c_r = (ct > 0) ? MAXV : MINV;
    m_accept = !rst && bus.in_valid && (!m_valid || bus.out_ready);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1; m_valid <= 1'b0; m_result <= 0; m_ovf <= 1'b0;
      m_zero <= 1'b0; m_neg <= 1'b0; m_sticky <= 1'b0; m_acc <= 0;
    end else begin
      if (m_accept) begin
        m_valid <= 1'b1; m_result <= c_r; m_ovf <= c_o;
        m_zero <= (c_r == 0); m_neg <= (c_r < 0);
        if (bus.op[1] && !bus.acc_clr) m_acc <= c_r;
      end else if (bus.out_ready) begin
        m_valid <= 1'b0;
      end
      if (bus.acc_clr) m_acc <= 0;
      if (STK && m_accept && c_o) m_sticky <= 1'b1;
      else if (bus.acc_clr) m_sticky <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", bus.in_ready, !rst && (!m_valid || bus.out_ready));
      chk("out_valid", bus.out_valid, m_valid);
      chk("result", $signed(bus.result), m_result);
      chk("ovf", bus.ovf, m_ovf);
      chk("zero", bus.zero, m_zero);
      chk("neg", bus.neg, m_neg);
      chk("ovf_sticky", bus.ovf_sticky, m_sticky);
      if (!rst && bus.out_valid && bus.out_ready) got.push_back(int'($signed(bus.result)));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int av, input int bv, input logic [1:0] o, input logic s, input logic clr);
    bit ok;
    bus.a = av[7:0];
    bus.b = bv[7:0];
    bus.op = o;
    bus.sat = s;
    bus.acc_clr = clr;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("send_accepted", ok, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.acc_clr = 1'b0;
    $display("[TB] beat a=%0d b=%0d op=%0d sat=%0d clr=%0d -> result=%0d ovf=%0d zero=%0d neg=%0d sticky=%0d",
             av, bv, o, s, clr, $signed(bus.result), bus.ovf, bus.zero, bus.neg, bus.ovf_sticky);
  endtask

  task automatic lit(input string name, input int r, input bit o);
    chk({name, "_result"}, $signed(bus.result), r);
    chk({name, "_ovf"}, bus.ovf, o);
    chk({name, "_valid"}, bus.out_valid, 1'b1);
  endtask

  task automatic clr_pulse();
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 2'b00;
    bus.sat = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
    idle(2);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", $signed(bus.result), 0);
    chk("rst_zero", bus.zero, 1'b0);
    rst = 1'b0;
    idle(1);

    // Plain add, wrap and saturate overflow.
    send(100, 27, 2'b00, 1'b0, 1'b0);  lit("add", 127, 1'b0);
    chk("add_neg", bus.neg, 1'b0); chk("add_zero", bus.zero, 1'b0);
    send(100, 50, 2'b00, 1'b0, 1'b0);  lit("wrap", -106, 1'b1);
    chk("wrap_neg", bus.neg, 1'b1);
    send(100, 50, 2'b00, 1'b1, 1'b0);  lit("satadd", 127, 1'b1);
    chk("satadd_neg", bus.neg, 1'b0);

    // Subtracting MIN.
    send(0, -128, 2'b01, 1'b0, 1'b0);  lit("submin_wrap", -128, 1'b1);
    send(0, -128, 2'b01, 1'b1, 1'b0);  lit("submin_sat", 127, 1'b1);
    send(-1, -128, 2'b01, 1'b0, 1'b0); lit("submin_ok", 127, 1'b0);
    send(5, -5, 2'b00, 1'b0, 1'b0);    lit("zero", 0, 1'b0);
    chk("zero_flag", bus.zero, 1'b1);

    // Accumulator chain with saturation, acc_clr alone and alongside an acc op.
    clr_pulse();
    send(120, 0, 2'b10, 1'b1, 1'b0);   lit("acc1", 120, 1'b0);
    send(120, 0, 2'b10, 1'b1, 1'b0);   lit("acc2", 127, 1'b1);
    send(7, 0, 2'b11, 1'b1, 1'b0);     lit("acc3", 120, 1'b0);
    clr_pulse();
    send(5, 0, 2'b10, 1'b1, 1'b0);     lit("acc4", 5, 1'b0);
    send(10, 0, 2'b10, 1'b0, 1'b1);    lit("acc_clr_same", 15, 1'b0);
    send(3, 0, 2'b10, 1'b0, 1'b0);     lit("acc_after_clr", 3, 1'b0);
    send(-128, 0, 2'b11, 1'b0, 1'b0);  lit("acc_sub_min", -125, 1'b1);

    // Sticky overflow behaviour.
    clr_pulse();
    chk("sticky_cleared", bus.ovf_sticky, 1'b0);
    send(100, 50, 2'b00, 1'b0, 1'b0);  lit("stk_ovf", -106, 1'b1);
    send(1, 2, 2'b00, 1'b0, 1'b0);     lit("stk_clean", 3, 1'b0);
    chk("stk_held", bus.ovf_sticky, STK);
    clr_pulse();
    chk("stk_clr", bus.ovf_sticky, 1'b0);
    send(100, 50, 2'b00, 1'b0, 1'b1);  lit("stk_setwins", -106, 1'b1);
    chk("stk_setwins_flag", bus.ovf_sticky, STK);

    // Back-pressure: first beat accepted, next one stalls three cycles, then all drain in order.
    idle(2);
    got.delete();
    bus.out_ready = 1'b0;
    send(1, 1, 2'b00, 1'b0, 1'b0);
    bus.a = 8'd2; bus.b = 8'd2; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_hold", $signed(bus.result), 2);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(2, 2, 2'b00, 1'b0, 1'b0);
    send(3, 3, 2'b00, 1'b0, 1'b0);
    send(4, 4, 2'b00, 1'b0, 1'b0);
    idle(2);
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_order", got[i], 2 * (i + 1));

    // Reset while a result is pending.
    bus.out_ready = 1'b0;
    send(100, 50, 2'b00, 1'b0, 1'b0);
    chk("pend_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_result", $signed(bus.result), 0);
    chk("mid_rst_ovf", bus.ovf, 1'b0);
    chk("mid_rst_neg", bus.neg, 1'b0);
    chk("mid_rst_sticky", bus.ovf_sticky, 1'b0);
    bus.out_ready = 1'b1;
    idle(1);
    send(120, 0, 2'b10, 1'b0, 1'b0);   lit("acc_after_rst", 120, 1'b0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
